spi_word_master: RTL and testbench

//  Host-side SPI initiator for the stepper command link: serialises 32-bit command words onto SCK/SSEL/MOSI.

---
 rtl/spi_word_master.sv | 176 +++++++++++++++++
 tb/tb_spi_word_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_master.sv
// spi_word_master: SPI mode-0 initiator for 32-bit command words.
// Bytes go out little-endian, each MSB first; MISO is gathered in the same order.
module spi_word_master #(
    parameter int CLK_DIV  = 4,
    parameter int SSEL_GAP = 8
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic [31:0] rx_word,
    output logic        rx_valid,
    output logic        busy,
    output logic        SCK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int GW = (SSEL_GAP > 0) ? $clog2(SSEL_GAP + 1) : 1;
    localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_END = GW'((SSEL_GAP > 0) ? SSEL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_END,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hc_q, hc_d, hc_inc;
    logic [4:0]    bit_q, bit_d, bit_inc;
    logic [GW-1:0] gc_q, gc_d;
    logic          sck_q, sck_d;
    logic          ssel_q, ssel_d;
    logic          mosi_q, mosi_d;
    logic [31:0]   tx_q, tx_d;
    logic [31:0]   rx_q, rx_d;
    logic          last_q, last_d;
    logic [31:0]   rxw_q, rxw_d;
    logic          rxv_q, rxv_d;
    logic          rdy_q, rdy_d;
    logic          accept, half_done;

    // Sequence index -> bit position: byte from the top bits, bit order reversed.
    function automatic logic [4:0] wire_pos(input logic [4:0] i);
        return {i[4:3], ~i[2:0]};
    endfunction

    assign accept    = word_valid && rdy_q;
    assign half_done = (hc_q == HALF_END);
    assign hc_inc    = hc_q + 1'b1;
    assign bit_inc   = bit_q + 5'd1;

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bit_d   = bit_q;
        gc_d    = gc_q;
        sck_d   = sck_q;
        ssel_d  = ssel_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        last_d  = last_q;
        rxw_d   = rxw_q;
        rxv_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    ssel_d  = 1'b0;
                    tx_d    = word_data;
                    last_d  = word_last;
                    mosi_d  = word_data[7];
                    hc_d    = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (half_done) begin
                    hc_d    = '0;
                    state_d = ST_SHIFT;
                end else begin
                    hc_d = hc_inc;
                end
            end
            ST_SHIFT: begin
                if (!half_done) begin
                    hc_d = hc_inc;
                end else begin
                    hc_d  = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_d[wire_pos(bit_q)] = MISO;
                    end else if (bit_q == 5'd31) begin
                        bit_d   = '0;
                        rxw_d   = rx_q;
                        rxv_d   = 1'b1;
                        state_d = last_q ? ST_END : ST_HOLD;
                    end else begin
                        bit_d  = bit_inc;
                        mosi_d = tx_q[wire_pos(bit_inc)];
                    end
                end
            end
            ST_END: begin
                if (half_done) begin
                    hc_d    = '0;
                    gc_d    = '0;
                    ssel_d  = 1'b1;
                    state_d = (SSEL_GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    hc_d = hc_inc;
                end
            end
            ST_GAP: begin
                if (gc_q == GAP_END) begin
                    state_d = ST_IDLE;
                end else begin
                    gc_d = gc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so it is already valid in the first IDLE/HOLD cycle.
        rdy_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            bit_q   <= '0;
            gc_q    <= '0;
            sck_q   <= 1'b0;
            ssel_q  <= 1'b1;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            last_q  <= 1'b0;
            rxw_q   <= '0;
            rxv_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            bit_q   <= bit_d;
            gc_q    <= gc_d;
            sck_q   <= sck_d;
            ssel_q  <= ssel_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            last_q  <= last_d;
            rxw_q   <= rxw_d;
            rxv_q   <= rxv_d;
            rdy_q   <= rdy_d;
        end
    end

    assign word_ready = rdy_q;
    assign rx_word    = rxw_q;
    assign rx_valid   = rxv_q;
    assign busy       = (state_q != ST_IDLE);
    assign SCK        = sck_q;
    assign SSEL       = ssel_q;
    assign MOSI       = mosi_q;

endmodule

// File: tb/tb_spi_word_master.sv
// Bench for spi_word_master: two parameter sets, each checked cycle by cycle
// against a timeline model derived from the accept cycle of each word.
module tb_spi_word_master;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    task automatic chk(input int g, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %h, want %h", g, nm, act, exp);
        end
    endtask

    task automatic chkb(input int g, input string nm,
                        input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cfg%0d %s: got %b, want %b", g, nm, act, exp);
        end
    endtask

    task automatic tmo(input int g, input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL cfg%0d timeout %s: got no event, want event", g, nm);
    endtask

    // Wire position of sequence bit i: byte i/8, MSB first within the byte.
    function automatic int wpos(input int i);
        return 8 * (i / 8) + 7 - (i % 8);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int D = (g == 0) ? 2 : 1;
        localparam int G = (g == 0) ? 3 : 0;

        logic        rstn = 1'b0;
        logic        wv = 1'b0, wl = 1'b0, miso = 1'b0;
        logic [31:0] wd = '0;
        logic        wr, rv, bz, sck, ssel, mosi;
        logic [31:0] rw;
        bit          loop = 1'b0;

        spi_word_master #(.CLK_DIV(D), .SSEL_GAP(G)) dut (
            .CLK(CLK), .resetn(rstn),
            .word_valid(wv), .word_data(wd), .word_last(wl),
            .word_ready(wr), .rx_word(rw), .rx_valid(rv), .busy(bz),
            .SCK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
        );

        // Model state: mode 0 = before first edge, 1 = after reset, 2 = word timeline.
        int          cyc = 0, mode = 0, rst_c = 0, acc_c = 0;
        logic [31:0] acc_d = '0, rx_acc = '0, e_rw = '0;
        bit          acc_l, e_rdy, e_bz, e_ssel, e_sck, e_mosi, e_rv, chk_mosi;

        initial begin
            int k, h;
            forever begin
                @(posedge CLK);
                cyc++;
                if (!rstn) begin
                    mode  = 1;
                    rst_c = cyc;
                    e_rw  = '0;
                end else if (mode != 0 && wv && e_rdy) begin
                    mode  = 2;
                    acc_c = cyc;
                    acc_d = wd;
                    acc_l = wl;
                end else if (mode == 2) begin
                    k = cyc - acc_c;
                    if (k >= 2 * D && k <= 64 * D && k % (2 * D) == 0)
                        rx_acc[wpos(k / (2 * D) - 1)] = miso;
                    if (k == 65 * D) e_rw = rx_acc;
                end
                e_rv = 1'b0;
                chk_mosi = 1'b0;
                if (mode == 1) begin
                    e_rdy    = (cyc > rst_c);
                    e_bz     = 1'b0;
                    e_ssel   = 1'b1;
                    e_sck    = 1'b0;
                    e_mosi   = 1'b0;
                    chk_mosi = (cyc == rst_c);
                end else if (mode == 2) begin
                    k = cyc - acc_c;
                    if (k < 65 * D) begin
                        h        = k / D;
                        e_sck    = (h >= 2) && (h % 2 == 0);
                        e_mosi   = acc_d[wpos((h == 0) ? 0 : (h - 1) / 2)];
                        chk_mosi = 1'b1;
                        e_ssel   = 1'b0;
                        e_bz     = 1'b1;
                        e_rdy    = 1'b0;
                    end else begin
                        e_sck = 1'b0;
                        e_rv  = (k == 65 * D);
                        if (!acc_l) begin
                            e_ssel = 1'b0;
                            e_bz   = 1'b1;
                            e_rdy  = 1'b1;
                        end else begin
                            e_ssel = (k >= 66 * D);
                            e_bz   = (k < 66 * D + G);
                            e_rdy  = (k >= 66 * D + G);
                        end
                    end
                end
            end
        end

        // Compare process plus edge monitors used by the directed checks.
        int          rises = 0, rvs = 0, srs = 0, rv_c = 0, sr_c = 0;
        logic [31:0] mon = '0;
        logic        p_sck = 1'b0, p_ssel = 1'b1;

        initial forever begin
            @(negedge CLK);
            if (mode != 0) begin
                chkb(g, "word_ready", wr, e_rdy);
                chkb(g, "busy", bz, e_bz);
                chkb(g, "SSEL", ssel, e_ssel);
                chkb(g, "SCK", sck, e_sck);
                chkb(g, "rx_valid", rv, e_rv);
                chk(g, "rx_word", rw, e_rw);
                if (chk_mosi) chkb(g, "MOSI", mosi, e_mosi);
            end
            if (sck && !p_sck) begin
                rises++;
                mon = {mon[30:0], mosi};
            end
            if (rv) begin
                rvs++;
                rv_c = cyc;
            end
            if (ssel && !p_ssel) begin
                srs++;
                sr_c = cyc;
            end
            p_sck  = sck;
            p_ssel = ssel;
        end

        initial forever begin
            @(negedge CLK);
            miso = loop ? mosi : 1'($urandom);
        end

        task automatic send(input logic [31:0] d, input logic l, output int a);
            int n;
            n = 0;
            @(negedge CLK);
            wv = 1'b1;
            wd = d;
            wl = l;
            while (!wr && n < 3000) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 3000) tmo(g, "send");
            @(negedge CLK);
            a  = cyc;
            wv = 1'b0;
            wd = $urandom;
            wl = 1'($urandom);
        endtask

        task automatic wait_done();
            int n;
            n = 0;
            @(negedge CLK);
            while ((bz || !wr) && n < 3000) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 3000) tmo(g, "idle");
            repeat (2) @(negedge CLK);
        endtask

        initial begin
            int a, br, bv, bs, n, bad;
            logic [31:0] msg [4];
            msg = '{32'h01000000, 32'h00001000, 32'h00000064, 32'h00000001};
            repeat (3) @(negedge CLK);
            chkb(g, "rst SSEL", ssel, 1'b1);
            chkb(g, "rst SCK", sck, 1'b0);
            chkb(g, "rst ready", wr, 1'b0);
            chkb(g, "rst busy", bz, 1'b0);
            chk(g, "rst rx_word", rw, 32'h0);
            rstn = 1'b1;

            br = rises; bv = rvs;
            send(32'h03000020, 1'b1, a);
            wait_done();
            chk(g, "t1 rises", rises - br, 32);
            chk(g, "t1 mosi bytes", mon, 32'h20000003);
            chk(g, "t1 latency", rv_c - a, 65 * D);
            chk(g, "t1 ssel delay", sr_c - rv_c, D);
            chk(g, "t1 rx pulses", rvs - bv, 1);

            loop = 1'b1;
            bv = rvs;
            send(32'hDEADBEEF, 1'b1, a);
            wait_done();
            loop = 1'b0;
            chk(g, "t2 loopback", rw, 32'hDEADBEEF);
            chk(g, "t2 rx pulses", rvs - bv, 1);

            br = rises; bv = rvs; bs = srs;
            for (int i = 0; i < 4; i++) send(msg[i], (i == 3), a);
            wait_done();
            chk(g, "t3 rises", rises - br, 128);
            chk(g, "t3 rx pulses", rvs - bv, 4);
            chk(g, "t3 ssel rises", srs - bs, 1);

            br = rises; bv = rvs;
            send($urandom, 1'b1, a);
            n = 0;
            while (rises - br < 14 && n < 3000) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 3000) tmo(g, "bit13");
            rstn = 1'b0;
            @(negedge CLK);
            rstn = 1'b1;
            chk(g, "t4 no rx", rvs - bv, 0);
            send($urandom, 1'b1, a);
            wait_done();
            chk(g, "t4 rx after", rvs - bv, 1);

            send($urandom, 1'b0, a);
            n = 0;
            while (!(wr && bz) && n < 3000) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 3000) tmo(g, "hold");
            bad = 0;
            repeat (50) begin
                @(negedge CLK);
                if (sck || ssel || !wr) bad++;
            end
            chk(g, "t5 stall", bad, 0);
            send($urandom, 1'b1, a);
            wait_done();

            br = rises; bv = rvs;
            for (int i = 0; i < 4; i++) send($urandom, 1'b1, a);
            wait_done();
            chk(g, "t6 rises", rises - br, 128);
            chk(g, "t6 rx pulses", rvs - bv, 4);

            for (int i = 0; i < 2500; i++) begin
                @(negedge CLK);
                wv = ($urandom_range(0, 2) != 0);
                wd = $urandom;
                wl = ($urandom_range(0, 2) == 0);
            end
            send($urandom, 1'b1, a);
            wait_done();
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && n_done < 2; i++) @(posedge CLK);
        if (n_done < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: got %0d finished configs, want 2", n_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
